// File: rtl/shiftregister_controller.sv
// shiftregister_controller
//   Sequences the JK-flip-flop left shift register for either a
//   parallel-to-serial transmit (preset load, then MSB-first shift-out) or a
//   serial-to-parallel receive (clear, shift in WIDTH bits, capture), behind a
//   start/busy/done handshake.
//
// Ports
//   clockpulse        in   system clock (rising edge), shared with the register
//   clear             in   asynchronous active-low reset
//   start             in   request pulse, only looked at while idle
//   mode              in   0 = transmit, 1 = receive
//   tx_data   [W]     in   word to transmit, captured when start is accepted
//   serial_in         in   receive line
//   serial_out        out  transmit line, IDLE_LEVEL when not shifting out
//   busy              out  high from the cycle after acceptance through DONE
//   done              out  one-cycle completion pulse
//   rx_data   [W]     out  last received word, held until the next receive ends
//   sr_clear          out  active-low clear to the register
//   sr_preset_enable  out  preset gate to the register
//   sr_preset [W]     out  preset word to the register
//   sr_serial_input   out  register bit0 input
//   sr_shift_enable   out  register clock enable
//   sr_q      [W]     in   register Q outputs
module shiftregister_controller #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sr_clear,
  output logic             sr_preset_enable,
  output logic [WIDTH-1:0] sr_preset,
  output logic             sr_serial_input,
  output logic             sr_shift_enable,
  input  logic [WIDTH-1:0] sr_q
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            mode_q;
  logic            clr_req;
  logic            last_shift;

  // Word the register will hold after one more left shift of bit b.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] q,
                                                input logic             b);
    logic [WIDTH:0] t;
    t = {q, b};
    return t[WIDTH-1:0];
  endfunction

  assign last_shift = (state == S_SHIFT) && (count == CW'(WIDTH - 1));

  // ---- state register ----
  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // ---- next state ----
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      S_IDLE:  if (start) state_nxt = mode ? S_CLR : S_LOAD;
      S_LOAD,
      S_CLR: begin
        state_nxt = S_SHIFT;
        count_nxt = '0;
      end
      S_SHIFT: begin
        if (last_shift) state_nxt = S_DONE;
        else            count_nxt = count + CW'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- registered outputs, decoded from the state being entered ----
  always_ff @(posedge clockpulse or negedge clear) begin
    if (!clear) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      rx_data          <= '0;
      sr_preset_enable <= 1'b0;
      sr_shift_enable  <= 1'b0;
      sr_preset        <= '0;
      clr_req          <= 1'b0;
      mode_q           <= 1'b0;
    end else begin
      busy             <= (state_nxt != S_IDLE);
      done             <= (state_nxt == S_DONE);
      sr_preset_enable <= (state_nxt == S_LOAD);
      sr_shift_enable  <= (state_nxt == S_SHIFT);
      clr_req          <= (state_nxt == S_CLR);
      if (state == S_IDLE && start) begin
        mode_q    <= mode;
        sr_preset <= tx_data;
      end
      // The register takes its final bit on this same edge, so capture the
      // word it is about to hold; rx_data is then valid alongside done.
      if (last_shift && mode_q)
        rx_data <= shift_in(sr_q, sr_serial_input);
    end
  end

  // Reset also clears the register, so clear is folded into sr_clear.
  assign sr_clear        = clear & ~clr_req;

  // The register samples its serial input on the shift edge itself, so the
  // receive line is passed straight through while a receive shift is running.
  assign sr_serial_input = (state == S_SHIFT && mode_q) ? serial_in : 1'b0;

  assign serial_out      = (state == S_SHIFT && !mode_q) ? sr_q[WIDTH-1]
                                                          : IDLE_LEVEL;

endmodule

// File: tb/tb_shiftregister_controller.sv
module tb_shiftregister_controller;

  localparam int   W        = 4;
  localparam logic IDLE_LVL = 1'b1;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         serial_in = 1'b0;

  logic         serial_out, busy, done;
  logic [W-1:0] rx_data;
  logic         sr_clear, sr_preset_enable, sr_serial_input, sr_shift_enable;
  logic [W-1:0] sr_preset;
  logic [W-1:0] sr_q;
  logic [W-1:0] sr_reg = '0;

  always #5 clk = ~clk;

  shiftregister_controller #(.WIDTH(W), .IDLE_LEVEL(IDLE_LVL)) dut (
    .clockpulse      (clk),
    .clear           (clear),
    .start           (start),
    .mode            (mode),
    .tx_data         (tx_data),
    .serial_in       (serial_in),
    .serial_out      (serial_out),
    .busy            (busy),
    .done            (done),
    .rx_data         (rx_data),
    .sr_clear        (sr_clear),
    .sr_preset_enable(sr_preset_enable),
    .sr_preset       (sr_preset),
    .sr_serial_input (sr_serial_input),
    .sr_shift_enable (sr_shift_enable),
    .sr_q            (sr_q)
  );

  // Shift register being controlled: async clear, async preset, left shift
  // on a clock edge when enabled.
  always @(posedge clk or negedge sr_clear or posedge sr_preset_enable) begin
    if (!sr_clear)             sr_reg <= '0;
    else if (sr_preset_enable) sr_reg <= sr_preset;
    else if (sr_shift_enable)  sr_reg <= {sr_reg[W-2:0], sr_serial_input};
  end
  assign sr_q = sr_reg;

  // Transaction-level reference: t = cycles since a start was accepted
  // (0 = idle, 1 = load/clear, 2..W+1 = shift, W+2 = done).
  int           t      = 0;
  logic         m_mode = 1'b0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_rx   = '0;
  logic [W-1:0] m_rxd  = '0;
  bit           chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle log of DUT activity for the directed literal checks.
  int           cyc_idx, done_cnt, done_at, load_cnt, load_at;
  logic [W-1:0] ser_log, preset_seen;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!clear) begin
      t = 0; m_rx = '0; m_rxd = '0;
    end else if (t == 0) begin
      if (start) begin
        t = 1; m_mode = mode; m_word = tx_data; m_rx = '0;
      end
    end else begin
      if (m_mode && t >= 2 && t <= W + 1) m_rx = {m_rx[W-2:0], serial_in};
      t = (t == W + 2) ? 0 : t + 1;
      if (t == W + 2 && m_mode) m_rxd = m_rx;
    end
  endtask

  task automatic clear_log();
    cyc_idx = -1; done_cnt = 0; done_at = -1; load_cnt = 0; load_at = -1;
    ser_log = '0; preset_seen = '0;
  endtask

  // One clock cycle: advance the model on the edge, drive this cycle's
  // inputs, then log what the DUT shows mid-cycle.
  task automatic cycle(input logic st, input logic md, input logic [W-1:0] tx,
                       input logic si, input logic clr);
    @(posedge clk);
    model_step();
    #2;
    start = st; mode = md; tx_data = tx; serial_in = si; clear = clr;
    if (!clr) begin
      t = 0; m_rx = '0; m_rxd = '0;
    end
    @(negedge clk);
    #1;
    cyc_idx++;
    if (sr_shift_enable) ser_log = {ser_log[W-2:0], serial_out};
    if (done) begin done_cnt++; done_at = cyc_idx; end
    if (sr_preset_enable) begin
      load_cnt++; load_at = cyc_idx; preset_seen = sr_preset;
    end
  endtask

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin : cmp
    logic sh;
    logic exp_so;
    logic exp_si;
    if (chk_en) begin
      sh     = (t >= 2 && t <= W + 1);
      exp_so = IDLE_LVL;
      exp_si = 1'b0;
      if (sh && !m_mode) exp_so = m_word[W-1-(t-2)];
      if (sh && m_mode)  exp_si = serial_in;
      chk("busy",            32'(busy),             32'(t != 0));
      chk("done",            32'(done),             32'(t == W + 2));
      chk("preset_enable",   32'(sr_preset_enable), 32'(t == 1 && !m_mode));
      chk("sr_clear",        32'(sr_clear),         32'(clear && !(t == 1 && m_mode)));
      chk("shift_enable",    32'(sr_shift_enable),  32'(sh));
      chk("serial_out",      32'(serial_out),       32'(exp_so));
      chk("sr_serial_input", 32'(sr_serial_input),  32'(exp_si));
      chk("rx_data",         32'(rx_data),          32'(m_rxd));
      if (t == 1 && !m_mode) chk("sr_preset", 32'(sr_preset), 32'(m_word));
      chk("interlock", 32'(sr_shift_enable & (sr_preset_enable | ~sr_clear)), 32'd0);
    end
  end

  initial begin
    logic [31:0] r;
    clear_log();
    #1 clear = 1'b0;
    chk_en = 1'b1;

    // Reset held
    cycle(0, 0, '0, 0, 0);
    cycle(0, 0, '0, 0, 0);
    chk("reset_busy",       32'(busy),       32'd0);
    chk("reset_sr_clear",   32'(sr_clear),   32'd0);
    chk("reset_serial_out", 32'(serial_out), 32'd1);
    chk("reset_rx_data",    32'(rx_data),    32'd0);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 1);

    // Transmit 1011; tx_data changes while busy must not matter
    clear_log();
    cycle(1, 0, 4'b1011, 0, 1);
    repeat (7) cycle(0, 1, 4'b0000, 0, 1);
    chk("tx_bits",       32'(ser_log),     32'(4'b1011));
    chk("tx_preset",     32'(preset_seen), 32'(4'b1011));
    chk("tx_done_cycle", 32'(done_at),     32'd6);
    chk("tx_done_count", 32'(done_cnt),    32'd1);
    chk("tx_idle_line",  32'(serial_out),  32'd1);

    // Receive 1,1,0,1
    clear_log();
    cycle(1, 1, 4'b0101, 0, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 1, 1);
    cycle(0, 0, '0, 1, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 1, 1);
    cycle(0, 0, '0, 0, 1);
    chk("rx_word",       32'(rx_data), 32'(4'b1101));
    chk("rx_done",       32'(done),    32'd1);
    chk("rx_done_cycle", 32'(done_at), 32'd6);
    cycle(0, 0, '0, 0, 1);

    // Transmit 0110, received word must hold
    clear_log();
    cycle(1, 0, 4'b0110, 1, 1);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, '0, 1, 1);
      chk("rx_hold", 32'(rx_data), 32'(4'b1101));
    end
    chk("tx2_bits", 32'(ser_log), 32'(4'b0110));

    // start held high: relaunch after DONE, with one idle cycle between
    clear_log();
    repeat (14) cycle(1, 0, 4'b1001, 0, 1);
    repeat (8)  cycle(0, 0, 4'b1001, 0, 1);
    chk("b2b_done_count", 32'(done_cnt), 32'd2);
    chk("b2b_load_count", 32'(load_cnt), 32'd2);
    chk("b2b_second_load", 32'(load_at), 32'd8);

    // start pulses during SHIFT and DONE are ignored
    clear_log();
    cycle(1, 1, '0, 1, 1);
    cycle(0, 1, '0, 0, 1);
    cycle(0, 1, '0, 1, 1);
    cycle(1, 1, '0, 0, 1);
    cycle(0, 1, '0, 1, 1);
    cycle(0, 1, '0, 1, 1);
    cycle(1, 1, '0, 0, 1);
    repeat (5) cycle(0, 1, '0, 0, 1);
    chk("ignore_done_count", 32'(done_cnt), 32'd1);
    chk("ignore_rx_word",    32'(rx_data),  32'(4'b1011));

    // Reset in the middle of a shift aborts without a done pulse
    clear_log();
    cycle(1, 0, 4'b1111, 0, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 1);
    cycle(0, 0, '0, 0, 0);
    chk("abort_busy",       32'(busy),       32'd0);
    chk("abort_done",       32'(done),       32'd0);
    chk("abort_sr_clear",   32'(sr_clear),   32'd0);
    chk("abort_serial_out", 32'(serial_out), 32'd1);
    cycle(0, 0, '0, 0, 0);
    repeat (8) cycle(0, 0, '0, 0, 1);
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Randomised traffic, occasional asynchronous reset
    for (int i = 0; i < 500; i++) begin
      r = $urandom;
      cycle(r[1:0] == 2'b00, r[2], r[6:3], r[7], r[15:8] != 8'd0);
    end
    cycle(0, 0, '0, 0, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
